// File: rtl/midi_voice_allocator.sv
// MIDI Note On/Off/All Notes Off parser and polyphonic voice scheduler with age-ranked allocation.
// Optional build macro VOICE_STEAL_EN: steal the oldest voice when every voice is gated.
module midi_voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CHANNEL    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              midiByte,
  input  logic                    midiByteReady,
  output logic [NUM_VOICES-1:0]   voiceGate,
  output logic [7*NUM_VOICES-1:0] voiceNote,
  output logic [7*NUM_VOICES-1:0] voiceVelocity,
  output logic [NUM_VOICES-1:0]   voiceTrigger,
  output logic                    allBusy
);

  localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [3:0]  CH = 4'(CHANNEL);
`ifdef VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_STATUS, WAIT_D1, WAIT_D2} parse_t;

  parse_t     r_state, w_state_n;
  logic       r_ready_d, w_accept;
  logic [3:0] r_status_hi;
  logic [6:0] r_d1, r_d2;
  logic       r_msg_valid;
  logic       w_load_status, w_load_d1, w_load_d2;

  // Parser next state; only the rising edge of ready accepts a byte
  always_comb begin
    w_state_n     = r_state;
    w_load_status = 1'b0;
    w_load_d1     = 1'b0;
    w_load_d2     = 1'b0;
    w_accept      = midiByteReady & ~r_ready_d;
    if (w_accept) begin
      if (midiByte[7]) begin
        if (midiByte[7:3] != 5'b11111) begin
          if (midiByte[3:0] == CH &&
              (midiByte[7:4] == 4'h8 || midiByte[7:4] == 4'h9 || midiByte[7:4] == 4'hB)) begin
            w_load_status = 1'b1;
            w_state_n     = WAIT_D1;
          end else begin
            w_state_n = WAIT_STATUS;
          end
        end
      end else begin
        case (r_state)
          WAIT_D1: begin
            w_load_d1 = 1'b1;
            w_state_n = WAIT_D2;
          end
          WAIT_D2: begin
            w_load_d2 = 1'b1;
            w_state_n = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= WAIT_STATUS;
      r_ready_d   <= 1'b0;
      r_status_hi <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_msg_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ready_d   <= midiByteReady;
      r_msg_valid <= w_load_d2;
      if (w_load_status) r_status_hi <= midiByte[7:4];
      if (w_load_d1)     r_d1        <= midiByte[6:0];
      if (w_load_d2)     r_d2        <= midiByte[6:0];
    end
  end

  logic       r_ev_on, r_ev_off, r_ev_all;
  logic [6:0] r_ev_note, r_ev_vel;

  // Event decode stage, one cycle after the second data byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ev_on   <= 1'b0;
      r_ev_off  <= 1'b0;
      r_ev_all  <= 1'b0;
      r_ev_note <= '0;
      r_ev_vel  <= '0;
    end else begin
      r_ev_on   <= r_msg_valid && r_status_hi == 4'h9 && r_d2 != 7'd0;
      r_ev_off  <= r_msg_valid && (r_status_hi == 4'h8 || (r_status_hi == 4'h9 && r_d2 == 7'd0));
      r_ev_all  <= r_msg_valid && r_status_hi == 4'hB && r_d1 == 7'd123;
      r_ev_note <= r_d1;
      r_ev_vel  <= r_d2;
    end
  end

  logic [NUM_VOICES-1:0]   r_gate, w_gate_n, r_trig, w_trig_n;
  logic [7*NUM_VOICES-1:0] r_note, w_note_n, r_vel, w_vel_n;
  logic [IW-1:0]           r_rank [NUM_VOICES];
  logic [IW-1:0]           w_rank_n [NUM_VOICES];
  logic                    r_all_busy;
  logic                    w_hit, w_free, w_alloc;
  logic [IW-1:0]           w_hit_idx, w_free_idx, w_old_idx, w_tgt, w_tgt_rank;

  // Voice search; descending scan so the lowest matching index wins
  always_comb begin
    w_hit      = 1'b0;
    w_free     = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_old_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_gate[v] && r_note[7*v +: 7] == r_ev_note) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(v);
      end
      if (!r_gate[v]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(v);
      end
      if (r_rank[v] == IW'(NUM_VOICES - 1)) w_old_idx = IW'(v);
    end
    w_tgt      = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_old_idx);
    w_tgt_rank = r_rank[w_tgt];
    w_alloc    = r_ev_on && (w_hit || w_free || STEAL_EN);
  end

  // Voice next state: allocate/retrigger/steal, release, all-off
  always_comb begin
    w_gate_n = r_gate;
    w_note_n = r_note;
    w_vel_n  = r_vel;
    w_trig_n = '0;
    w_rank_n = r_rank;
    if (w_alloc) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (IW'(v) == w_tgt) begin
          w_gate_n[v]        = 1'b1;
          w_note_n[7*v +: 7] = r_ev_note;
          w_vel_n[7*v +: 7]  = r_ev_vel;
          w_trig_n[v]        = 1'b1;
          w_rank_n[v]        = '0;
        end else if (r_rank[v] < w_tgt_rank) begin
          w_rank_n[v] = r_rank[v] + IW'(1);
        end
      end
    end
    if (r_ev_off) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (r_gate[v] && r_note[7*v +: 7] == r_ev_note) w_gate_n[v] = 1'b0;
      end
    end
    if (r_ev_all) w_gate_n = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gate     <= '0;
      r_note     <= '0;
      r_vel      <= '0;
      r_trig     <= '0;
      r_all_busy <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) r_rank[v] <= IW'(v);
    end else begin
      r_gate     <= w_gate_n;
      r_note     <= w_note_n;
      r_vel      <= w_vel_n;
      r_trig     <= w_trig_n;
      r_all_busy <= &w_gate_n;
      r_rank     <= w_rank_n;
    end
  end

  assign voiceGate     = r_gate;
  assign voiceNote     = r_note;
  assign voiceVelocity = r_vel;
  assign voiceTrigger  = r_trig;
  assign allBusy       = r_all_busy;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator; expectations follow VOICE_STEAL_EN when defined.
module tb_midi_voice_allocator;
  localparam int unsigned NV = 4;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      midiByte = 8'h00;
  logic            midiByteReady = 1'b0;
  logic [NV-1:0]   voiceGate, voiceTrigger;
  logic [7*NV-1:0] voiceNote, voiceVelocity;
  logic            allBusy;

  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
    .clock(clock), .reset(reset), .midiByte(midiByte), .midiByteReady(midiByteReady),
    .voiceGate(voiceGate), .voiceNote(voiceNote), .voiceVelocity(voiceVelocity),
    .voiceTrigger(voiceTrigger), .allBusy(allBusy)
  );

  always #10 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int trig_cnt [NV] = '{default: 0};
  int t0 [NV];

  always @(negedge clock)
    for (int i = 0; i < NV; i++) trig_cnt[i] <= trig_cnt[i] + int'(voiceTrigger[i]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clock);
    midiByte = b;
    midiByteReady = 1'b1;
    repeat (hold) @(negedge clock);
    midiByteReady = 1'b0;
    @(negedge clock);
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [6:0] note_of(input int i);
    return voiceNote[7*i +: 7];
  endfunction

  function automatic logic [6:0] vel_of(input int i);
    return voiceVelocity[7*i +: 7];
  endfunction

  function automatic int dtrig(input int i);
    return trig_cnt[i] - t0[i];
  endfunction

  function automatic int dtotal();
    int s = 0;
    for (int i = 0; i < NV; i++) s += trig_cnt[i] - t0[i];
    return s;
  endfunction

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_gate", 32'(voiceGate), 32'h0);
    chk("rst_note", 32'(voiceNote), 32'h0);
    chk("rst_vel", 32'(voiceVelocity), 32'h0);
    chk("rst_trig", 32'(voiceTrigger), 32'h0);
    chk("rst_busy", 32'(allBusy), 32'h0);

    // Scenario 1 with exact latency: outputs appear 2 clocks after the d2 accept edge
    send(8'h90, 1);
    send(8'h3C, 1);
    @(negedge clock);
    midiByte = 8'h64;
    midiByteReady = 1'b1;
    @(negedge clock);
    midiByteReady = 1'b0;
    chk("s1_trig_e0", 32'(voiceTrigger), 32'h0);
    @(negedge clock);
    chk("s1_gate_e1", 32'(voiceGate), 32'h0);
    chk("s1_trig_e1", 32'(voiceTrigger), 32'h0);
    @(negedge clock);
    chk("s1_trig_e2", 32'(voiceTrigger), 32'h1);
    chk("s1_gate_e2", 32'(voiceGate), 32'h1);
    chk("s1_note0", 32'(note_of(0)), 32'd60);
    chk("s1_vel0", 32'(vel_of(0)), 32'd100);
    @(negedge clock);
    chk("s1_trig_e3", 32'(voiceTrigger), 32'h0);
    settle();

    // Scenario 2: running status, note off keeps note
    send(8'h40, 1); send(8'h50, 1); settle();
    chk("s2_gate_on", 32'(voiceGate), 32'h3);
    chk("s2_note1", 32'(note_of(1)), 32'd64);
    chk("s2_vel1", 32'(vel_of(1)), 32'd80);
    send(8'h3C, 1); send(8'h00, 1); settle();
    chk("s2_gate_off", 32'(voiceGate), 32'h2);
    chk("s2_note0_kept", 32'(note_of(0)), 32'd60);
    send(8'h80, 1); send(8'h50, 1); send(8'h40, 1); settle();
    chk("s2_off_unheld", 32'(voiceGate), 32'h2);
    chk("s2_busy", 32'(allBusy), 32'h0);

    // Scenario 3: fill every voice, then overflow
    pulse_reset();
    send(8'h90, 1);
    for (int n = 60; n < 64; n++) begin
      send(8'(n), 1); send(8'h64, 1);
    end
    settle();
    chk("s3_gate_full", 32'(voiceGate), 32'hF);
    chk("s3_busy", 32'(allBusy), 32'h1);
    chk("s3_note3", 32'(note_of(3)), 32'd63);
    t0 = trig_cnt;
    send(8'd64, 1); send(8'h64, 1); settle();
    chk("s3_steal_note0", 32'(note_of(0)), STEAL ? 32'd64 : 32'd60);
    chk("s3_steal_trig0", 32'(dtrig(0)), STEAL ? 32'd1 : 32'd0);
    chk("s3_steal_total", 32'(dtotal()), STEAL ? 32'd1 : 32'd0);
    chk("s3_gate_after", 32'(voiceGate), 32'hF);
    send(8'd65, 1); send(8'h64, 1); settle();
    chk("s3_steal_note1", 32'(note_of(1)), STEAL ? 32'd65 : 32'd61);
    chk("s3_note0_again", 32'(note_of(0)), STEAL ? 32'd64 : 32'd60);

    // Scenario 4: real-time byte, foreign channel, all notes off
    pulse_reset();
    send(8'h90, 1); send(8'h3C, 1); send(8'hF8, 1); send(8'h64, 1); settle();
    chk("s4_rt_gate", 32'(voiceGate), 32'h1);
    chk("s4_rt_note0", 32'(note_of(0)), 32'd60);
    chk("s4_rt_vel0", 32'(vel_of(0)), 32'd100);
    send(8'h91, 1); send(8'h3D, 1); send(8'h64, 1); settle();
    chk("s4_ch1_gate", 32'(voiceGate), 32'h1);
    chk("s4_ch1_note1", 32'(note_of(1)), 32'd0);
    send(8'h90, 1); send(8'h3D, 1); send(8'h64, 1); send(8'h3E, 1); send(8'h64, 1); settle();
    chk("s4_three_gated", 32'(voiceGate), 32'h7);
    t0 = trig_cnt;
    send(8'hB0, 1); send(8'h7B, 1); send(8'h00, 1); settle();
    chk("s4_alloff_gate", 32'(voiceGate), 32'h0);
    chk("s4_alloff_busy", 32'(allBusy), 32'h0);
    chk("s4_alloff_trig", 32'(dtotal()), 32'd0);
    chk("s4_alloff_note2", 32'(note_of(2)), 32'd62);

    // Scenario 5: ready held high for many cycles per byte
    pulse_reset();
    t0 = trig_cnt;
    send(8'h90, 50); send(8'h3C, 50); send(8'h64, 50); settle();
    chk("s5_gate", 32'(voiceGate), 32'h1);
    chk("s5_trig_total", 32'(dtotal()), 32'd1);
    t0 = trig_cnt;
    send(8'h90, 3); send(8'h3C, 3); send(8'h70, 3); settle();
    chk("s5_retrig_gate", 32'(voiceGate), 32'h1);
    chk("s5_retrig_t0", 32'(dtrig(0)), 32'd1);
    chk("s5_retrig_t1", 32'(dtrig(1)), 32'd0);
    chk("s5_retrig_vel", 32'(vel_of(0)), 32'h70);

    // Scenario 6: reset in the middle of a message
    pulse_reset();
    t0 = trig_cnt;
    send(8'h90, 1); send(8'h3C, 1);
    pulse_reset();
    send(8'h64, 1); settle();
    chk("s6_gate", 32'(voiceGate), 32'h0);
    chk("s6_note", 32'(voiceNote), 32'h0);
    send(8'h3C, 1); send(8'h64, 1); settle();
    chk("s6_wait_status", 32'(voiceGate), 32'h0);
    chk("s6_trig", 32'(dtotal()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
